basic_adder: RTL and testbench

- Address-generation adder used by memory-side queues (one instance per store-queue issue slot).
- Computes the effective address rs1 + immediate for a load or store in the same cycle. The store queue latches this combinational `result` into the target entry.
- Also decodes access size and misalignment, and provides a registered copy of the results for pipelined consumers.

---
 rtl/basic_adder.sv | 84 ++++++++
 tb/tb_basic_adder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/basic_adder.sv
// Address-generation adder for one store-queue issue slot.
// Effective address, size/misalign decode, plus a registered copy.
module basic_adder #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            valid,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] rs1_value,
    output logic [XLEN-1:0] result,
    output logic [1:0]      mem_size,
    output logic            is_mem,
    output logic            misaligned,
    output logic [XLEN-1:0] result_q,
    output logic [1:0]      mem_size_q,
    output logic            misaligned_q,
    output logic            valid_q
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic [6:0]      opcode;
    logic            is_load;
    logic            is_store;
    logic [11:0]     imm12;
    logic [XLEN-1:0] imm;
    logic            size_bad;

    // rs1 specifier and the unsigned-load bit play no part in addressing
    logic            unused_fields;

    assign opcode        = inst[6:0];
    assign is_load       = (opcode == OP_LOAD);
    assign is_store      = (opcode == OP_STORE);
    assign is_mem        = is_load | is_store;
    assign mem_size      = inst[13:12];
    assign unused_fields = ^inst[19:14];

    // Pick the 12-bit immediate field by instruction format
    always_comb begin
        imm12 = 12'd0;
        unique case (1'b1)
            is_store: imm12 = {inst[31:25], inst[11:7]};
            is_load:  imm12 = inst[31:20];
            default:  imm12 = 12'd0;
        endcase
    end

    // Sign-extend and add; carry-out is intentionally dropped
    always_comb begin
        imm    = {{(XLEN-12){imm12[11]}}, imm12};
        result = rs1_value + imm;
    end

    // Low address bits must be clear for the access width; size 3 is illegal
    always_comb begin
        size_bad = 1'b0;
        case (mem_size)
            2'd0:    size_bad = 1'b0;
            2'd1:    size_bad = result[0];
            2'd2:    size_bad = |result[1:0];
            default: size_bad = 1'b1;
        endcase
        misaligned = valid & is_mem & size_bad;
    end

    // Pipeline copy for downstream consumers, captured every cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q     <= '0;
            mem_size_q   <= 2'd0;
            misaligned_q <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            result_q     <= result;
            mem_size_q   <= mem_size;
            misaligned_q <= misaligned;
            valid_q      <= valid & is_mem;
        end
    end

endmodule

// File: tb/tb_basic_adder.sv
// Self-checking bench for basic_adder: directed table, async reset
// sequence, and random stimulus against an arithmetic reference model.
module tb_basic_adder;

    logic        clock;
    logic        reset;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] rs1_value;
    logic [31:0] result;
    logic [1:0]  mem_size;
    logic        is_mem;
    logic        misaligned;
    logic [31:0] result_q;
    logic [1:0]  mem_size_q;
    logic        misaligned_q;
    logic        valid_q;

    int n_vec = 0;
    int n_err = 0;

    basic_adder #(.XLEN(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .valid        (valid),
        .inst         (inst),
        .rs1_value    (rs1_value),
        .result       (result),
        .mem_size     (mem_size),
        .is_mem       (is_mem),
        .misaligned   (misaligned),
        .result_q     (result_q),
        .mem_size_q   (mem_size_q),
        .misaligned_q (misaligned_q),
        .valid_q      (valid_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic [31:0] rs1;
        logic [31:0] res;
        logic [1:0]  sz;
        logic        mem;
        logic        mis;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: decode fields numerically, add in 64-bit, reduce mod 2^32
    task automatic model(input logic v, input logic [31:0] ins,
                         input logic [31:0] rs1, output logic [31:0] res,
                         output logic [1:0] sz, output logic mem,
                         output logic mis);
        longint op, imm, addr, bytes, f3;
        op  = longint'(ins) % 128;
        f3  = (longint'(ins) / 4096) % 8;
        imm = 0;
        if (op == 35)
            imm = (longint'(ins) / 33554432) * 32 + (longint'(ins) / 128) % 32;
        else if (op == 3)
            imm = longint'(ins) / 1048576;
        if (imm >= 2048) imm = imm - 4096;
        addr  = (longint'(rs1) + imm + 64'sd4294967296) % 64'sd4294967296;
        res   = addr[31:0];
        sz    = f3[1:0];
        mem   = (op == 3) || (op == 35);
        bytes = 1 << (f3 % 4);
        mis   = v && mem && ((f3 % 4 == 3) || (addr % bytes != 0));
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [31:0] rs1);
        @(negedge clock);
        valid     = v;
        inst      = ins;
        rs1_value = rs1;
        #1;
    endtask

    task automatic check_comb(input logic [31:0] res, input logic [1:0] sz,
                              input logic mem, input logic mis);
        check("result", result, res);
        check("mem_size", {30'd0, mem_size}, {30'd0, sz});
        check("is_mem", {31'd0, is_mem}, {31'd0, mem});
        check("misaligned", {31'd0, misaligned}, {31'd0, mis});
    endtask

    task automatic check_reg(input logic [31:0] res, input logic [1:0] sz,
                             input logic mis, input logic vq);
        @(posedge clock);
        #1;
        check("result_q", result_q, res);
        check("mem_size_q", {30'd0, mem_size_q}, {30'd0, sz});
        check("misaligned_q", {31'd0, misaligned_q}, {31'd0, mis});
        check("valid_q", {31'd0, valid_q}, {31'd0, vq});
    endtask

    task automatic check_q_zero(input string tag);
        check({tag, "_result_q"}, result_q, 32'd0);
        check({tag, "_mem_size_q"}, {30'd0, mem_size_q}, 32'd0);
        check({tag, "_misaligned_q"}, {31'd0, misaligned_q}, 32'd0);
        check({tag, "_valid_q"}, {31'd0, valid_q}, 32'd0);
    endtask

    initial begin
        logic [31:0] er;
        logic [1:0]  es;
        logic        em;
        logic        ei;
        logic [31:0] ins;
        logic [31:0] rs1;
        logic        v;
        logic [2:0]  f3;

        tbl[0] = '{1'b1, 32'hFE20AE23, 32'h00001000, 32'h00000FFC, 2'd2, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 32'h0080A183, 32'hFFFFFFFC, 32'h00000004, 2'd2, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 32'h002090A3, 32'h00000100, 32'h00000101, 2'd1, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 32'h002081B3, 32'h12345678, 32'h12345678, 2'd0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 32'h002090A3, 32'h00000100, 32'h00000101, 2'd1, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 32'h0000B183, 32'h00000100, 32'h00000100, 2'd3, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 32'h00308183, 32'h00000100, 32'h00000103, 2'd0, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 32'h0020A183, 32'h00000100, 32'h00000102, 2'd2, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 32'h0010C183, 32'h00000100, 32'h00000101, 2'd0, 1'b1, 1'b0};
        tbl[9] = '{1'b1, 32'h80008183, 32'h00000000, 32'hFFFFF800, 2'd0, 1'b1, 1'b0};

        reset     = 1'b1;
        valid     = 1'b0;
        inst      = 32'h0;
        rs1_value = 32'h0;
        #1;
        check_q_zero("reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int k = 0; k < 10; k++) begin
            drive(tbl[k].v, tbl[k].ins, tbl[k].rs1);
            check_comb(tbl[k].res, tbl[k].sz, tbl[k].mem, tbl[k].mis);
            check_reg(tbl[k].res, tbl[k].sz, tbl[k].mis,
                      tbl[k].v & tbl[k].mem);
        end

        // Async reset between edges with a live registered entry
        drive(1'b1, 32'hFE20AE23, 32'h00001000);
        check_reg(32'h00000FFC, 2'd2, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_q_zero("async");
        check("reset_comb_result", result, 32'h00000FFC);
        @(posedge clock);
        #1;
        check_q_zero("hold");
        drive(1'b1, 32'h002090A3, 32'h00000100);
        reset = 1'b0;
        check_reg(32'h00000101, 2'd1, 1'b1, 1'b1);

        // Randomized stimulus against the reference model
        for (int k = 0; k < 300; k++) begin
            f3  = 3'($urandom_range(0, 7));
            ins = $urandom;
            case ($urandom_range(0, 2))
                0: ins = {ins[31:15], f3, ins[11:7], 7'b0000011};
                1: ins = {ins[31:15], f3, ins[11:7], 7'b0100011};
                default: ;
            endcase
            rs1 = $urandom;
            if ($urandom_range(0, 3) == 0) rs1 = 32'hFFFFFFFF - 32'($urandom_range(0, 8));
            v = ($urandom_range(0, 4) != 0);
            model(v, ins, rs1, er, es, em, ei);
            drive(v, ins, rs1);
            check_comb(er, es, em, ei);
            check_reg(er, es, ei, v & em);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
